// File: rtl/test_verdict_monitor.sv
// test_verdict_monitor
//   In-simulation verdict engine. Counts severity-tagged check events from
//   NCH channels while a test runs, applies a timeout watchdog and a drain
//   window, then raises a single finish pulse with a pass/fail verdict and
//   a cause code. DONE is sticky until reset.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active-high (aborts any run, no finish)
//   i_start      begin run (IDLE only)
//   i_done       stimulus complete (RUN only)
//   i_chk_valid  per-channel event strobe
//   i_chk_sev    per-channel severity, ch k at [2k+1:2k]: 0 info 1 warn 2 err 3 fatal
//   o_state      0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//   o_finish     one-cycle pulse on first DONE cycle
//   o_pass       verdict pass (DONE only)
//   o_fail       verdict fail (DONE only)
//   o_cause      0 none, 1 fatal, 2 timeout, 3 error/warn threshold
//   o_info_cnt   saturating info count
//   o_warn_cnt   saturating warning count
//   o_err_cnt    saturating error count (fatal included)
//   o_cycles     saturating cycles spent in RUN+DRAIN
module test_verdict_monitor #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned DRAIN       = 4,
    parameter int unsigned WARN_AS_ERR = 0,
    parameter int unsigned MAX_ERR     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_done,
    input  logic [NCH-1:0]       i_chk_valid,
    input  logic [2*NCH-1:0]     i_chk_sev,
    output logic [2:0]           o_state,
    output logic                 o_finish,
    output logic                 o_pass,
    output logic                 o_fail,
    output logic [1:0]           o_cause,
    output logic [CNT_W-1:0]     o_info_cnt,
    output logic [CNT_W-1:0]     o_warn_cnt,
    output logic [CNT_W-1:0]     o_err_cnt,
    output logic [CYC_W-1:0]     o_cycles
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3
    } state_t;

    localparam int unsigned      DRN_W     = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;
    localparam logic [DRN_W-1:0] DRN_LOAD  = DRN_W'(DRAIN);
    localparam logic [CYC_W-1:0] TO_LAST   = CYC_W'(TIMEOUT - 1);
    // A tolerance at or above the counter ceiling can never be exceeded.
    localparam bit               ERR_NEVER = (MAX_ERR >= (2**CNT_W) - 1);
    localparam logic [CNT_W-1:0] ERR_LIM   = ERR_NEVER ? '1 : CNT_W'(MAX_ERR);

    state_t           r_state, w_nxt_state;
    logic [DRN_W-1:0] r_drain, w_nxt_drain;
    logic [CNT_W-1:0] r_info, r_warn, r_err;
    logic [CNT_W-1:0] w_info_nxt, w_warn_nxt, w_err_nxt;
    logic [CYC_W-1:0] r_cycles, w_cycles_nxt;
    logic             r_finish, r_pass, r_fail;
    logic [1:0]       r_cause;
    logic [4:0]       w_pop_info, w_pop_warn, w_pop_err;
    logic             w_fatal, w_active, w_timeout, w_thresh;
    logic             w_end, w_end_fail;
    logic [1:0]       w_end_cause;

    // Popcount is at most 5 bits wide, so the carry above CNT_W flags overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [4:0] b);
        logic [CNT_W+4:0] s;
        s = {5'd0, a} + {{CNT_W{1'b0}}, b};
        return (s[CNT_W+4:CNT_W] != 5'd0) ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        w_pop_info = '0;
        w_pop_warn = '0;
        w_pop_err  = '0;
        w_fatal    = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (i_chk_valid[k]) begin
                case (i_chk_sev[2*k +: 2])
                    2'd0: w_pop_info = w_pop_info + 5'd1;
                    2'd1: w_pop_warn = w_pop_warn + 5'd1;
                    2'd2: w_pop_err  = w_pop_err + 5'd1;
                    default: begin
                        w_pop_err = w_pop_err + 5'd1;
                        w_fatal   = 1'b1;
                    end
                endcase
            end
        end
    end

    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_info_nxt = sat_add(r_info, w_pop_info);
    assign w_warn_nxt = sat_add(r_warn, w_pop_warn);
    assign w_err_nxt  = sat_add(r_err, w_pop_err);
    assign w_timeout  = (TIMEOUT != 0) && (r_cycles == TO_LAST);
    // Threshold uses the post-update counts so final-cycle events are included.
    assign w_thresh   = (!ERR_NEVER && (w_err_nxt > ERR_LIM)) ||
                        ((WARN_AS_ERR != 0) && (w_warn_nxt != '0));

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_drain = r_drain;
        w_end       = 1'b0;
        w_end_fail  = 1'b0;
        w_end_cause = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_nxt_state = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                if (w_fatal) begin
                    w_end       = 1'b1;
                    w_end_fail  = 1'b1;
                    w_end_cause = 2'd1;
                end else if (w_timeout) begin
                    w_end       = 1'b1;
                    w_end_fail  = 1'b1;
                    w_end_cause = 2'd2;
                end else if ((r_state == S_RUN) && i_done) begin
                    if (DRAIN == 0) begin
                        w_end       = 1'b1;
                        w_end_fail  = w_thresh;
                        w_end_cause = w_thresh ? 2'd3 : 2'd0;
                    end else begin
                        w_nxt_state = S_DRAIN;
                        w_nxt_drain = DRN_LOAD;
                    end
                end else if (r_state == S_DRAIN) begin
                    if (r_drain <= DRN_W'(1)) begin
                        w_end       = 1'b1;
                        w_end_fail  = w_thresh;
                        w_end_cause = w_thresh ? 2'd3 : 2'd0;
                    end else begin
                        w_nxt_drain = r_drain - DRN_W'(1);
                    end
                end
                if (w_end) w_nxt_state = S_DONE;
            end
            default: ;
        endcase
    end

    // The cycle count holds on the DONE-entry edge, so a timeout reports TIMEOUT-1.
    assign w_cycles_nxt = (!w_end && (r_cycles != '1)) ? r_cycles + CYC_W'(1) : r_cycles;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_drain  <= '0;
            r_info   <= '0;
            r_warn   <= '0;
            r_err    <= '0;
            r_cycles <= '0;
            r_finish <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_cause  <= 2'd0;
        end else begin
            r_state  <= w_nxt_state;
            r_drain  <= w_nxt_drain;
            r_finish <= w_end;
            if ((r_state == S_IDLE) && i_start) begin
                r_info   <= '0;
                r_warn   <= '0;
                r_err    <= '0;
                r_cycles <= '0;
            end else if (w_active) begin
                r_info   <= w_info_nxt;
                r_warn   <= w_warn_nxt;
                r_err    <= w_err_nxt;
                r_cycles <= w_cycles_nxt;
            end
            if (w_end) begin
                r_pass  <= !w_end_fail;
                r_fail  <= w_end_fail;
                r_cause <= w_end_cause;
            end
        end
    end

    assign o_state    = r_state;
    assign o_finish   = r_finish;
    assign o_pass     = r_pass;
    assign o_fail     = r_fail;
    assign o_cause    = r_cause;
    assign o_info_cnt = r_info;
    assign o_warn_cnt = r_warn;
    assign o_err_cnt  = r_err;
    assign o_cycles   = r_cycles;

endmodule

// File: tb/tb_test_verdict_monitor.sv
// Bench for test_verdict_monitor: two differently parameterised instances
// share one stimulus stream; an integer-level model of each is compared
// against the outputs every cycle, plus directed literal checks.
module tb_test_verdict_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic [3:0] vld = '0;
    logic [7:0] sev = '0;

    logic [2:0]  s0, s1;
    logic        f0, f1, p0, p1, x0, x1;
    logic [1:0]  c0, c1;
    logic [2:0]  i0, w0, e0;
    logic [7:0]  i1, w1, e1;
    logic [15:0] y0, y1;

    always #5 clk = ~clk;

    test_verdict_monitor #(
        .NCH(4), .CNT_W(3), .CYC_W(16), .TIMEOUT(20), .DRAIN(4),
        .WARN_AS_ERR(0), .MAX_ERR(2)
    ) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_done(done),
        .i_chk_valid(vld), .i_chk_sev(sev),
        .o_state(s0), .o_finish(f0), .o_pass(p0), .o_fail(x0), .o_cause(c0),
        .o_info_cnt(i0), .o_warn_cnt(w0), .o_err_cnt(e0), .o_cycles(y0)
    );

    test_verdict_monitor #(
        .NCH(4), .CNT_W(8), .CYC_W(16), .TIMEOUT(0), .DRAIN(0),
        .WARN_AS_ERR(1), .MAX_ERR(0)
    ) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_done(done),
        .i_chk_valid(vld), .i_chk_sev(sev),
        .o_state(s1), .o_finish(f1), .o_pass(p1), .o_fail(x1), .o_cause(c1),
        .o_info_cnt(i1), .o_warn_cnt(w1), .o_err_cnt(e1), .o_cycles(y1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    int P_CNTW[2] = '{3, 8};
    int P_TO[2]   = '{20, 0};
    int P_DR[2]   = '{4, 0};
    int P_WAE[2]  = '{0, 1};
    int P_ME[2]   = '{2, 0};

    int m_ph[2], m_dl[2], m_ci[2], m_cw[2], m_ce[2], m_cy[2];
    int m_fn[2], m_ps[2], m_fl[2], m_cs[2];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic mstep(input int m);
        int ni, nw, ne, nf, cmax, cause;
        bit ending, fail;
        logic [1:0] s;
        cmax = (1 << P_CNTW[m]) - 1;
        m_fn[m] = 0;
        if (rst) begin
            m_ph[m] = 0; m_ci[m] = 0; m_cw[m] = 0; m_ce[m] = 0; m_cy[m] = 0;
            m_ps[m] = 0; m_fl[m] = 0; m_cs[m] = 0;
            return;
        end
        if (m_ph[m] == 0) begin
            if (start) begin
                m_ph[m] = 1; m_ci[m] = 0; m_cw[m] = 0; m_ce[m] = 0; m_cy[m] = 0;
            end
            return;
        end
        if (m_ph[m] == 3) return;
        ni = 0; nw = 0; ne = 0; nf = 0;
        for (int k = 0; k < 4; k++) begin
            s = sev[2*k +: 2];
            if (vld[k]) begin
                if (s == 0) ni++;
                else if (s == 1) nw++;
                else if (s == 2) ne++;
                else nf++;
            end
        end
        m_ci[m] = imin(m_ci[m] + ni, cmax);
        m_cw[m] = imin(m_cw[m] + nw, cmax);
        m_ce[m] = imin(m_ce[m] + ne + nf, cmax);
        ending = 0; fail = 0; cause = 0;
        if (nf > 0) begin
            ending = 1; fail = 1; cause = 1;
        end else if (P_TO[m] != 0 && m_cy[m] == P_TO[m] - 1) begin
            ending = 1; fail = 1; cause = 2;
        end else if ((m_ph[m] == 1 && done && P_DR[m] == 0) || (m_ph[m] == 2 && m_dl[m] == 1)) begin
            ending = 1;
            fail = (m_ce[m] > P_ME[m]) || (P_WAE[m] != 0 && m_cw[m] > 0);
            cause = fail ? 3 : 0;
        end else if (m_ph[m] == 1 && done) begin
            m_ph[m] = 2; m_dl[m] = P_DR[m];
        end else if (m_ph[m] == 2) begin
            m_dl[m]--;
        end
        if (ending) begin
            m_ph[m] = 3; m_fn[m] = 1; m_ps[m] = !fail; m_fl[m] = fail; m_cs[m] = cause;
        end else begin
            m_cy[m] = imin(m_cy[m] + 1, 65535);
        end
    endtask

    always @(posedge clk) begin
        mstep(0);
        mstep(1);
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("u0.state", s0, m_ph[0]);   chk("u1.state", s1, m_ph[1]);
            chk("u0.finish", f0, m_fn[0]);  chk("u1.finish", f1, m_fn[1]);
            chk("u0.pass", p0, m_ps[0]);    chk("u1.pass", p1, m_ps[1]);
            chk("u0.fail", x0, m_fl[0]);    chk("u1.fail", x1, m_fl[1]);
            chk("u0.cause", c0, m_cs[0]);   chk("u1.cause", c1, m_cs[1]);
            chk("u0.info", i0, m_ci[0]);    chk("u1.info", i1, m_ci[1]);
            chk("u0.warn", w0, m_cw[0]);    chk("u1.warn", w1, m_cw[1]);
            chk("u0.err", e0, m_ce[0]);     chk("u1.err", e1, m_ce[1]);
            chk("u0.cycles", y0, m_cy[0]);  chk("u1.cycles", y1, m_cy[1]);
        end
    end

    int drn0 = 0;
    int fin0 = 0;
    always @(negedge clk) begin
        if (s0 == 3'd2) drn0++;
        if (f0) fin0++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; done = 1'b0; vld = '0; sev = '0;
        tick();
        rst = 1'b0;
        drn0 = 0; fin0 = 0;
    endtask

    task automatic run_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        for (int n = 0; n < budget && s0 != 3'd3; n++) tick();
        chk("u0.reach_done", s0, 3);
    endtask

    initial begin
        tick();
        do_reset();
        chk_en = 1;
        chk("rst.state", s0, 0);
        chk("rst.err", e0, 0);
        chk("rst.finish", f0, 0);

        // three info events, normal finish through a 4-cycle drain
        run_start();
        vld = 4'b0001; sev = 8'h00;
        repeat (3) tick();
        vld = '0; done = 1'b1;
        tick();
        done = 1'b0;
        wait_done0(20);
        repeat (2) tick();
        chk("A.drain_cycles", drn0, 4);
        chk("A.finish_pulses", fin0, 1);
        chk("A.pass", p0, 1);
        chk("A.info", i0, 3);
        chk("A.cause", c0, 0);

        // four simultaneous errors exceed MAX_ERR=2
        do_reset();
        run_start();
        vld = 4'b1111; sev = 8'hAA;
        tick();
        vld = '0; sev = '0;
        chk("B.err_next", e0, 4);
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_done0(20);
        chk("B.fail", x0, 1);
        chk("B.cause", c0, 3);

        // fatal on ch2 alongside done: straight to DONE
        do_reset();
        run_start();
        vld = 4'b0100; sev = 8'h30; done = 1'b1;
        tick();
        vld = '0; sev = '0; done = 1'b0;
        chk("C.state", s0, 3);
        chk("C.finish", f0, 1);
        chk("C.fail", x0, 1);
        chk("C.cause", c0, 1);
        chk("C.err", e0, 1);

        // no done: watchdog
        do_reset();
        run_start();
        wait_done0(40);
        chk("D.cycles", y0, 19);
        chk("D.fail", x0, 1);
        chk("D.cause", c0, 2);

        // ten warnings: saturation and warn-as-error
        do_reset();
        run_start();
        vld = 4'b0010; sev = 8'h04;
        repeat (10) tick();
        vld = '0; sev = '0; done = 1'b1;
        tick();
        done = 1'b0;
        wait_done0(20);
        chk("E.warn_sat", w0, 7);
        chk("E.pass", p0, 1);
        chk("E.u1_warn", w1, 10);
        chk("E.u1_fail", x1, 1);
        chk("E.u1_cause", c1, 3);

        // reset during drain
        do_reset();
        run_start();
        vld = 4'b0001; sev = 8'h02;
        done = 1'b1;
        tick();
        vld = '0; sev = '0; done = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("F.state", s0, 0);
        chk("F.err", e0, 0);
        chk("F.cycles", y0, 0);
        chk("F.no_finish", fin0, 0);
        run_start();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_done0(20);
        chk("F.rerun_pass", p0, 1);

        // randomized runs against the model
        for (int r = 0; r < 40; r++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                logic [1:0] sv;
                start = ($urandom_range(0, 3) == 0);
                done  = ($urandom_range(0, 14) == 0);
                rst   = ($urandom_range(0, 99) == 0);
                vld   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
                for (int k = 0; k < 4; k++) begin
                    sv = 2'($urandom_range(0, 3));
                    if (sv == 2'd3 && $urandom_range(0, 29) != 0) sv = 2'($urandom_range(0, 2));
                    sev[2*k +: 2] = sv;
                end
                tick();
            end
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/test_verdict_monitor.md
Name: test_verdict_monitor

Overview:
- Parametrised in-simulation verdict engine for the testcase suite; successor to the ad-hoc single-test display/assert/finish pattern.
- Collects check events from NCH channels, each tagged with a severity: info, warning, error or fatal.
- Runs a timeout watchdog and a drain window, then issues a single finish pulse with a pass/fail verdict and a cause code.
- Instantiated inside a test module next to the stimulus; the bench calls $finish from o_finish.

Parameters:
- NCH, 4, number of independent check-event channels (1..16)
- CNT_W, 8, width of each severity counter; counters saturate
- CYC_W, 16, width of the run-cycle counter and of TIMEOUT
- TIMEOUT, 1000, maximum RUN+DRAIN cycles before forced fail; 0 disables the watchdog
- DRAIN, 4, cycles spent in DRAIN after i_done before the verdict (0 allowed)
- WARN_AS_ERR, 0, 1 = any warning causes fail
- MAX_ERR, 0, errors tolerated; fail if error count > MAX_ERR

Ports:
- i_clk  input  1  single clock
- i_rst  input  1  synchronous reset, active-high
- i_start  input  1  begin run; honoured only in IDLE
- i_done  input  1  stimulus complete; honoured only in RUN
- i_chk_valid  input  NCH  per-channel check-event strobe
- i_chk_sev  input  2*NCH  per-channel severity; channel k uses bits [2k+1:2k]; 0=info, 1=warn, 2=error, 3=fatal
- o_state  output  3  0=IDLE, 1=RUN, 2=DRAIN, 3=DONE
- o_finish  output  1  one-cycle pulse on entry to DONE
- o_pass  output  1  verdict pass; valid in DONE
- o_fail  output  1  verdict fail; valid in DONE
- o_cause  output  2  0=none, 1=fatal, 2=timeout, 3=error/warn threshold
- o_info_cnt  output  CNT_W  info event count
- o_warn_cnt  output  CNT_W  warning event count
- o_err_cnt  output  CNT_W  error event count (fatal events included)
- o_cycles  output  CYC_W  cycles spent in RUN+DRAIN

Behaviour:

Reset
- i_rst high at a clock edge: state=IDLE; all counters 0; o_finish=0, o_pass=0, o_fail=0, o_cause=0.
- Reset in any state, including mid-DRAIN, aborts the run. No finish pulse is issued.

State machine
- IDLE: events are ignored. On i_start, clear all counters and o_cycles, then go to RUN.
- RUN: o_cycles increments each cycle. On i_done, go to DRAIN and load drain counter = DRAIN. If DRAIN=0, go directly to DONE.
- DRAIN: events are still counted. Drain counter decrements each cycle; at 1, go to DONE on the next edge. Total DRAIN cycles equal the DRAIN parameter.
- DONE: sticky until reset. i_start and events are ignored. Counters and verdict hold.

Event counting
- Active in RUN and DRAIN only.
- Each cycle, each counter adds the number of valid channels with the matching severity (popcount, 0..NCH).
- Fatal events add to o_err_cnt.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Counter updates are visible the cycle after the strobe.

Fatal event
- A valid channel with sev=3 forces DONE on the next edge, whether in RUN or DRAIN.
- Verdict: fail, cause=1.
- Takes priority over i_done and over timeout in the same cycle.

Watchdog (TIMEOUT≠0)
- When o_cycles reaches TIMEOUT-1 while in RUN/DRAIN with no fatal event that cycle, go to DONE.
- Verdict: fail, cause=2.
- Timeout beats i_done in the same cycle.
- o_cycles saturates at 2^CYC_W-1.

Normal verdict on DONE entry
- Fail with cause=3 if err_cnt > MAX_ERR, or if WARN_AS_ERR=1 and warn_cnt > 0.
- Otherwise pass with cause=0.
- The threshold uses counts including events of the final DRAIN cycle.

Verdict outputs
- o_pass and o_fail are mutually exclusive. Both are 0 outside DONE.
- o_finish is high exactly one cycle, the first cycle o_state=3.

Test Plan:
- Reset, start, 3 info events on ch0, done with DRAIN=4 -> DRAIN lasts 4 cycles, o_finish pulses once, o_pass=1, o_info_cnt=3, o_cause=0.
- All 4 channels strobe error in one cycle, MAX_ERR=2 -> o_err_cnt=4 next cycle; after done, o_fail=1, o_cause=3.
- ch2 fatal in the same cycle as i_done -> DONE next cycle, o_fail=1, o_cause=1, DRAIN skipped, o_err_cnt=1.
- TIMEOUT=20, i_done never asserted -> o_finish when o_cycles=19, o_fail=1, o_cause=2.
- CNT_W=3, 10 warnings with WARN_AS_ERR=0 -> o_warn_cnt saturates at 7, o_pass=1. Repeat with WARN_AS_ERR=1 -> o_fail=1, o_cause=3.
- Reset asserted during DRAIN -> o_state=0, counters 0, no o_finish. A subsequent i_start runs cleanly to pass.
